// File: rtl/alu_pkg.sv
// alu_pkg: ALU op encodings and arbiter FSM states shared by the ALU arbiter slice.
package alu_pkg;
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational WIDTH-bit ALU (add, sub, and, or); results wrap, carry discarded.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] y
);
    always_comb begin
        y = (op == ALU_ADD) ? a + b :
            (op == ALU_SUB) ? a + ~b + WIDTH'(1) :
            (op == ALU_AND) ? a & b : a | b;
    end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin arbiter sequencing the shared ALU.
// Accept in IDLE, evaluate in EXEC, hold the registered result in RESP until taken.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_op,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             busy
);
    state_t           state, next_state;
    logic             prio, gnt, sel, accept, done;
    logic [WIDTH-1:0] a_q, b_q, y;
    logic [1:0]       op_q;

    // Contention goes to prio; otherwise the lone valid requester wins.
    assign sel       = (req_valid == 2'b11) ? prio : req_valid[1];
    assign req_ready = (rst_n && state == ST_IDLE && |req_valid) ? (sel ? 2'b10 : 2'b01) : 2'b00;
    assign accept    = |(req_valid & req_ready);
    assign done      = (state == ST_RESP) && rsp_ready[gnt];
    assign rsp_valid = (state == ST_RESP) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    assign busy      = (state != ST_IDLE);

    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: next_state = accept ? ST_EXEC : ST_IDLE;
            ST_EXEC: next_state = ST_RESP;
            ST_RESP: next_state = done ? ST_IDLE : ST_RESP;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a (a_q),
        .b (b_q),
        .op(op_q),
        .y (y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio     <= 1'b0;
            gnt      <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= ALU_ADD;
            rsp_data <= '0;
            rsp_zero <= 1'b0;
        end else begin
            if (accept) begin
                gnt  <= sel;
                a_q  <= sel ? req1_a : req0_a;
                b_q  <= sel ? req1_b : req0_b;
                op_q <= sel ? req1_op : req0_op;
            end
            if (state == ST_EXEC) begin
                rsp_data <= y;
                rsp_zero <= (y == '0);
            end
            if (done) prio <= ~gnt;
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: table-driven directed checks plus backpressure and mid-operation reset sequences.
module tb_alu_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = 2'b00, req_ready, rsp_valid, rsp_ready = 2'b11;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0, rsp_data;
    logic [1:0]  req0_op = 2'b00, req1_op = 2'b00;
    logic        rsp_zero, busy;
    int          n_chk = 0, n_fail = 0;

    typedef struct {
        logic [1:0]  valid;
        logic [31:0] a0, b0;
        logic [1:0]  op0;
        logic [31:0] a1, b1;
        logic [1:0]  op1;
        logic        g;
        logic [31:0] data;
        logic        zero;
    } vec_t;
    vec_t tbl[9];

    alu_arbiter #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_zero(rsp_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_outputs(input string tag);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
    endtask

    // Drive one request, check grant, latency, result and completion.
    task automatic do_op(input vec_t v, input string tag);
        logic [1:0] oh;
        oh = v.g ? 2'b10 : 2'b01;
        @(negedge clk);
        req_valid = v.valid;
        req0_a = v.a0; req0_b = v.b0; req0_op = v.op0;
        req1_a = v.a1; req1_b = v.b1; req1_op = v.op1;
        #1;
        chk({tag, " req_ready"}, 32'(req_ready), 32'(oh));
        chk({tag, " busy idle"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk({tag, " req_ready exec"}, 32'(req_ready), 32'd0);
        chk({tag, " rsp_valid exec"}, 32'(rsp_valid), 32'd0);
        chk({tag, " busy exec"}, 32'(busy), 32'd1);
        @(posedge clk); #1;
        chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'(oh));
        chk({tag, " rsp_data"}, rsp_data, v.data);
        chk({tag, " rsp_zero"}, 32'(rsp_zero), 32'(v.zero));
        @(posedge clk); #1;
        chk({tag, " done"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        tbl[0] = '{2'b01, 32'd5, 32'd3, 2'b00, 32'd0, 32'd0, 2'b00, 1'b0, 32'd8, 1'b0};
        tbl[1] = '{2'b10, 32'd0, 32'd0, 2'b00, 32'd3, 32'd5, 2'b01, 1'b1, 32'hFFFF_FFFE, 1'b0};
        tbl[2] = '{2'b10, 32'd0, 32'd0, 2'b00, 32'd7, 32'd7, 2'b01, 1'b1, 32'd0, 1'b1};
        tbl[3] = '{2'b11, 32'hF0F0_F0F0, 32'hFF00_FF00, 2'b10, 32'hF0F0_F0F0, 32'hFF00_FF00, 2'b11, 1'b0, 32'hF000_F000, 1'b0};
        tbl[4] = '{2'b11, 32'hF0F0_F0F0, 32'hFF00_FF00, 2'b10, 32'hF0F0_F0F0, 32'hFF00_FF00, 2'b11, 1'b1, 32'hFFF0_FFF0, 1'b0};
        tbl[5] = '{2'b11, 32'hF0F0_F0F0, 32'hFF00_FF00, 2'b10, 32'hF0F0_F0F0, 32'hFF00_FF00, 2'b11, 1'b0, 32'hF000_F000, 1'b0};
        tbl[6] = '{2'b11, 32'hF0F0_F0F0, 32'hFF00_FF00, 2'b10, 32'hF0F0_F0F0, 32'hFF00_FF00, 2'b11, 1'b1, 32'hFFF0_FFF0, 1'b0};
        tbl[7] = '{2'b01, 32'hFFFF_FFFF, 32'd1, 2'b00, 32'd0, 32'd0, 2'b00, 1'b0, 32'd0, 1'b1};
        tbl[8] = '{2'b01, 32'd0, 32'd1, 2'b01, 32'd9, 32'd9, 2'b00, 1'b0, 32'hFFFF_FFFF, 1'b0};

        req_valid = 2'b11;
        #12;
        chk("reset req_ready", 32'(req_ready), 32'd0);
        chk("reset rsp_data", rsp_data, 32'd0);
        chk("reset rsp_zero", 32'(rsp_zero), 32'd0);
        idle_outputs("reset");
        @(negedge clk);
        req_valid = 2'b00;
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) do_op(tbl[i], $sformatf("vec%0d", i));

        // Backpressure: prio is 1 here, req1 granted, response held for several cycles.
        @(negedge clk);
        rsp_ready = 2'b00;
        req_valid = 2'b10;
        req1_a = 32'h100; req1_b = 32'h23; req1_op = 2'b11;
        #1 chk("bp req_ready", 32'(req_ready), 32'b10);
        @(posedge clk); #1;
        req_valid = 2'b11;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp rsp_valid", 32'(rsp_valid), 32'b10);
            chk("bp rsp_data", rsp_data, 32'h123);
            chk("bp req_ready", 32'(req_ready), 32'd0);
            chk("bp busy", 32'(busy), 32'd1);
            @(posedge clk); #1;
        end
        rsp_ready = 2'b01;
        @(posedge clk); #1;
        chk("bp other bit ignored", 32'(rsp_valid), 32'b10);
        rsp_ready = 2'b10;
        @(posedge clk); #1;
        idle_outputs("bp done");
        chk("bp prio flipped", 32'(req_ready), 32'b01);
        rsp_ready = 2'b11;

        do_op('{2'b01, 32'd4, 32'd6, 2'b00, 32'd0, 32'd0, 2'b00, 1'b0, 32'd10, 1'b0}, "pre_rst");

        // Reset during EXEC with prio at 1 must abort and clear prio.
        @(negedge clk);
        req_valid = 2'b10;
        req1_a = 32'd1; req1_b = 32'd2; req1_op = 2'b00;
        #1 chk("rst req_ready", 32'(req_ready), 32'b10);
        @(posedge clk); #1;
        chk("rst in exec", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        idle_outputs("rst async");
        chk("rst req_ready forced", 32'(req_ready), 32'd0);
        chk("rst rsp_data", rsp_data, 32'd0);
        chk("rst rsp_zero", 32'(rsp_zero), 32'd0);
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            idle_outputs("post rst");
        end
        req_valid = 2'b11;
        #1 chk("post rst prio", 32'(req_ready), 32'b01);
        req_valid = 2'b00;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
